// File: rtl/vt52_keyenc.sv
// -----------------------------------------------------------------------------
// vt52_keyenc
//
// Keyboard-side VT52 encoder. Decoded key events are buffered in a small FIFO
// and turned into the byte stream a VT52 sends to the host: plain ASCII bytes,
// or ESC-prefixed two-byte sequences for the cursor and PF keys. When the
// VT52_IDENT_EN macro is defined, an identify request from the screen decoder
// (ESC Z) is answered with ESC / K. Bytes are handed to the UART transmitter
// through a load strobe (tx_set) and an idle level (tx_done).
//
// Configuration macro:
//   VT52_IDENT_EN  defined   -> ident_req is honoured (ESC / K response)
//                  undefined -> ident_req is ignored, no ident logic built
//
// Parameters:
//   FIFO_AW    log2 of the key FIFO depth (default 3 -> 8 entries)
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   key_valid  one-cycle strobe, key_code valid
//   key_code   bit7=0: ASCII in [6:0]; 0x80..0x83 up/down/right/left,
//              0x84..0x86 PF1..PF3; 0x87..0xFF are ignored
//   ident_req  one-cycle identify request strobe
//   tx_data    byte presented to the UART (held until the next tx_set)
//   tx_set     one-cycle load pulse to the UART
//   tx_done    UART idle level (1 = idle)
//   fifo_full  key FIFO holds 2^FIFO_AW entries (registered)
//   key_drop   one-cycle pulse, a legal key was discarded because the FIFO
//              was full
// -----------------------------------------------------------------------------
module vt52_keyenc #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       ident_req,
  output logic [7:0] tx_data,
  output logic       tx_set,
  input  logic       tx_done,
  output logic       fifo_full,
  output logic       key_drop
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [7:0]       ESC      = 8'h1B;

  // Index of the last byte of a sequence: ident=2, special key=1, ASCII=0.
  function automatic logic [1:0] seq_last(input logic is_ident, input logic [7:0] code);
    logic [1:0] last;
    if (is_ident) begin
      last = 2'd2;
    end else if (code[7]) begin
      last = 2'd1;
    end else begin
      last = 2'd0;
    end
    return last;
  endfunction

  // Byte number idx of the sequence for the given event.
  function automatic logic [7:0] enc_byte(input logic is_ident, input logic [7:0] code,
                                          input logic [1:0] idx);
    logic [7:0] b;
    if (is_ident) begin
      case (idx)
        2'd0:    b = ESC;
        2'd1:    b = 8'h2F;
        2'd2:    b = 8'h4B;
        default: b = 8'h00;
      endcase
    end else if (code[7]) begin
      if (idx == 2'd0) begin
        b = ESC;
      end else begin
        case (code[2:0])
          3'd0:    b = 8'h41;
          3'd1:    b = 8'h42;
          3'd2:    b = 8'h43;
          3'd3:    b = 8'h44;
          3'd4:    b = 8'h50;
          3'd5:    b = 8'h51;
          3'd6:    b = 8'h52;
          default: b = 8'h00;
        endcase
      end
    end else begin
      b = {1'b0, code[6:0]};
    end
    return b;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_next_s;
  logic               full_s;
  logic               empty_s;
  logic               legal_s;
  logic               push_s;
  logic               pop_s;
  logic [7:0]         head_s;

  // Sequencer
  state_t             state_r;
  state_t             state_next_s;
  logic               launch_ident_s;
  logic               advance_s;
  logic               is_ident_r;
  logic [7:0]         cur_code_r;
  logic [1:0]         byte_idx_r;
  logic [1:0]         next_idx_s;
  logic               tx_done_r;
  logic               tx_done_prev_r;
  logic               done_rise_s;
  logic               ident_pend_s;

  // Output registers
  logic [7:0]         tx_data_r;
  logic               tx_set_r;
  logic               fifo_full_r;
  logic               key_drop_r;

  // Fullness is judged on the registered count, so a key arriving while full
  // is dropped even if a pop happens in the same cycle.
  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == {(FIFO_AW + 1){1'b0}});
  assign legal_s     = (key_code <= 8'h86);
  assign push_s      = key_valid & legal_s & ~full_s;
  assign head_s      = mem_r[rd_ptr_r];
  assign done_rise_s = tx_done_r & ~tx_done_prev_r;
  assign next_idx_s  = byte_idx_r + 2'd1;

`ifdef VT52_IDENT_EN
  logic ident_pend_r;

  // Sticky identify request; a new request wins over the clear of a launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ident_pend_r <= 1'b0;
    end else if (ident_req) begin
      ident_pend_r <= 1'b1;
    end else if (launch_ident_s) begin
      ident_pend_r <= 1'b0;
    end else begin
      ident_pend_r <= ident_pend_r;
    end
  end

  assign ident_pend_s = ident_pend_r;
`else
  logic unused_ident_s;

  assign unused_ident_s = ident_req;
  assign ident_pend_s   = 1'b0;
`endif

  // Next FIFO occupancy from this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, count, full flag and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {FIFO_AW{1'b0}};
      rd_ptr_r    <= {FIFO_AW{1'b0}};
      count_r     <= {(FIFO_AW + 1){1'b0}};
      fifo_full_r <= 1'b0;
      key_drop_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
      end
      count_r     <= count_next_s;
      fifo_full_r <= (count_next_s == FULL_CNT);
      key_drop_r  <= key_valid & legal_s & full_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers/count do.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_r[wr_ptr_r] <= key_code;
    end
  end

  // tx_done history; both stages reset to idle so a done edge left over from
  // a transmission that straddled reset cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done_r      <= 1'b1;
      tx_done_prev_r <= 1'b1;
    end else begin
      tx_done_r      <= tx_done;
      tx_done_prev_r <= tx_done_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and launch/advance decisions. IDLE launches only on the
  // raw tx_done level so a busy UART is never overrun; ident beats keys.
  always_comb begin
    state_next_s   = state_r;
    pop_s          = 1'b0;
    launch_ident_s = 1'b0;
    advance_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_done && ident_pend_s) begin
          launch_ident_s = 1'b1;
          state_next_s   = ST_LOAD;
        end else if (tx_done && !empty_s) begin
          pop_s        = 1'b1;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise_s) begin
          if (byte_idx_r < seq_last(is_ident_r, cur_code_r)) begin
            advance_s    = 1'b1;
            state_next_s = ST_LOAD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequence context and registered UART outputs; tx_set is high exactly in
  // the LOAD cycle, with the matching byte on tx_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_ident_r <= 1'b0;
      cur_code_r <= 8'h00;
      byte_idx_r <= 2'd0;
      tx_data_r  <= 8'h00;
      tx_set_r   <= 1'b0;
    end else if (launch_ident_s) begin
      is_ident_r <= 1'b1;
      cur_code_r <= 8'h00;
      byte_idx_r <= 2'd0;
      tx_data_r  <= enc_byte(1'b1, 8'h00, 2'd0);
      tx_set_r   <= 1'b1;
    end else if (pop_s) begin
      is_ident_r <= 1'b0;
      cur_code_r <= head_s;
      byte_idx_r <= 2'd0;
      tx_data_r  <= enc_byte(1'b0, head_s, 2'd0);
      tx_set_r   <= 1'b1;
    end else if (advance_s) begin
      byte_idx_r <= next_idx_s;
      tx_data_r  <= enc_byte(is_ident_r, cur_code_r, next_idx_s);
      tx_set_r   <= 1'b1;
    end else begin
      tx_set_r   <= 1'b0;
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_set    = tx_set_r;
  assign fifo_full = fifo_full_r;
  assign key_drop  = key_drop_r;

endmodule

// File: tb/tb_vt52_keyenc.sv
// -----------------------------------------------------------------------------
// tb_vt52_keyenc
//
// Directed bench for vt52_keyenc. Expected host bytes come from a queue filled
// from the VT52 encoding rules; a compare process checks every tx_set byte
// against it and checks tx_data is held in between. A behavioural UART model
// drives tx_done. Directed checks pin latency, FIFO full/drop behaviour,
// ident coalescing and reset mid-sequence.
// -----------------------------------------------------------------------------
module tb_vt52_keyenc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       ident_req = 1'b0;
  logic [7:0] tx_data;
  logic       tx_set;
  logic       tx_done;
  logic       fifo_full;
  logic       key_drop;

  vt52_keyenc #(.FIFO_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .ident_req (ident_req),
    .tx_data   (tx_data),
    .tx_set    (tx_set),
    .tx_done   (tx_done),
    .fifo_full (fifo_full),
    .key_drop  (key_drop)
  );

  initial forever #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         set_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] special_tab [7];

  // UART model controls
  bit         uart_auto = 1'b1;
  bit         tx_done_man = 1'b1;
  int         uart_len = 3;
  int         rise_cyc = 0;
  int         rise_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected host bytes for one key event, from the VT52 key table.
  task automatic expect_key(input logic [7:0] code);
    int idx;
    if (code < 8'h80) begin
      exp_q.push_back(code);
    end else if (code <= 8'h86) begin
      idx = int'(code) - 128;
      exp_q.push_back(8'h1B);
      exp_q.push_back(special_tab[idx]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_set(input string name, input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (tx_set) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_set_seen"}, 32'(found), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (n < 3000 && !(exp_q.size() == 0 && quiet >= 8)) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && tx_done && !tx_set) quiet++;
      else quiet = 0;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model: goes busy on tx_set for uart_len cycles, else idle
  initial begin
    int  busy;
    bit  nxt;
    busy = 0;
    tx_done = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (uart_auto) begin
        if (tx_set) begin
          busy = uart_len;
          nxt = 1'b0;
        end else begin
          if (busy > 0) busy--;
          nxt = (busy == 0);
        end
      end else begin
        nxt = tx_done_man;
      end
      if (nxt && !tx_done) begin
        rise_cyc = cyc;
        rise_cnt++;
      end
      tx_done = nxt;
    end
  end

  // compare process: every tx_set byte against the model queue, hold otherwise
  initial begin
    logic [7:0] last_data;
    logic [7:0] exp_byte;
    last_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_data = 8'h00;
      end else if (tx_set) begin
        set_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx_set actual=0x%0h required=no_tx_set", tx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(exp_byte));
          last_data = exp_byte;
        end
      end else begin
        chk("tx_hold", 32'(tx_data), 32'(last_data));
      end
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int r0;
    int sc;
    int mcount;
    bit prev_full;
    bit prev_drop;
    bit drop_now;
    bit found;

    special_tab = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h50, 8'h51, 8'h52};

    // ---- reset state ----
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_set", 32'(tx_set), 32'd0);
    chk("rst_key_drop", 32'(key_drop), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // ---- 1: ASCII 0x61, latency N+2 ----
    uart_len = 3;
    key_code = 8'h61;
    key_valid = 1'b1;
    expect_key(8'h61);
    n0 = cyc;
    step();
    key_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_set_n1", 32'(tx_set), 32'd0);
    step();
    @(negedge clk);
    chk("t1_set_n2", 32'(tx_set), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h61);
    chk("t1_cycle", 32'(cyc - n0), 32'd2);
    drain("t1");

    // ---- 2: cursor up, second byte two cycles after tx_done rises ----
    uart_len = 100;
    step();
    key_code = 8'h80;
    key_valid = 1'b1;
    expect_key(8'h80);
    step();
    key_valid = 1'b0;
    wait_set("t2_first", 10);
    chk("t2_first_data", 32'(tx_data), 32'h1B);
    r0 = rise_cnt;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rise_cnt != r0) begin
        found = 1'b1;
        break;
      end
    end
    chk("t2_rise_seen", 32'(found), 32'd1);
    wait_set("t2_second", 10);
    chk("t2_second_delay", 32'(cyc - rise_cyc), 32'd2);
    chk("t2_second_data", 32'(tx_data), 32'h41);
    drain("t2");
    uart_len = 3;

    // ---- 6: illegal codes ignored, 0x86 boundary legal ----
    step();
    key_code = 8'h90;
    key_valid = 1'b1;
    step();
    key_code = 8'h87;
    step();
    key_valid = 1'b0;
    sc = set_count;
    repeat (10) begin
      @(negedge clk);
      chk("t6_no_drop", 32'(key_drop), 32'd0);
    end
    chk("t6_not_full", 32'(fifo_full), 32'd0);
    chk("t6_no_set", 32'(set_count), 32'(sc));
    step();
    key_code = 8'h86;
    key_valid = 1'b1;
    expect_key(8'h86);
    step();
    key_valid = 1'b0;
    drain("t6_pf3");

    // ---- 3: FIFO fill with tx_done held low, 9th key dropped ----
    tx_done_man = 1'b0;
    uart_auto = 1'b0;
    step();
    step();
    mcount = 0;
    prev_full = 1'b0;
    prev_drop = 1'b0;
    for (int i = 0; i < 9; i++) begin
      key_code = 8'h30 + 8'(i);
      key_valid = 1'b1;
      drop_now = (mcount == 8);
      if (!drop_now) begin
        expect_key(key_code);
        mcount++;
      end
      @(negedge clk);
      chk("t3_full", 32'(fifo_full), 32'(prev_full));
      chk("t3_drop", 32'(key_drop), 32'(prev_drop));
      prev_full = (mcount == 8);
      prev_drop = drop_now;
      step();
    end
    key_valid = 1'b0;
    @(negedge clk);
    chk("t3_full_after9", 32'(fifo_full), 32'd1);
    chk("t3_drop_on9", 32'(key_drop), 32'd1);
    step();
    @(negedge clk);
    chk("t3_drop_single", 32'(key_drop), 32'd0);
    chk("t3_still_full", 32'(fifo_full), 32'd1);
    step();
    tx_done_man = 1'b1;
    uart_auto = 1'b1;
    drain("t3");
    chk("t3_full_cleared", 32'(fifo_full), 32'd0);

    // ---- 4: cursor left with ident requests during the first byte ----
    uart_len = 8;
    step();
    key_code = 8'h83;
    key_valid = 1'b1;
    expect_key(8'h83);
    step();
    key_valid = 1'b0;
    wait_set("t4_first", 10);
    chk("t4_first_data", 32'(tx_data), 32'h1B);
    step();
    ident_req = 1'b1;
    step();
    ident_req = 1'b0;
    step();
    ident_req = 1'b1;
    step();
    ident_req = 1'b0;
`ifdef VT52_IDENT_EN
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h2F);
    exp_q.push_back(8'h4B);
`endif
    drain("t4");

    // ---- 5: PF1, reset after ESC; new key waits for tx_done ----
    uart_len = 20;
    step();
    key_code = 8'h84;
    key_valid = 1'b1;
    expect_key(8'h84);
    step();
    key_valid = 1'b0;
    wait_set("t5_first", 10);
    chk("t5_first_data", 32'(tx_data), 32'h1B);
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    @(negedge clk);
    chk("t5_rst_tx_data", 32'(tx_data), 32'h00);
    chk("t5_rst_tx_set", 32'(tx_set), 32'd0);
    chk("t5_rst_key_drop", 32'(key_drop), 32'd0);
    chk("t5_rst_fifo_full", 32'(fifo_full), 32'd0);
    step();
    reset = 1'b0;
    key_code = 8'h61;
    key_valid = 1'b1;
    expect_key(8'h61);
    r0 = rise_cnt;
    step();
    key_valid = 1'b0;
    wait_set("t5_new", 40);
    chk("t5_waited_for_done", 32'(rise_cnt != r0), 32'd1);
    chk("t5_launch_delay", 32'(cyc - rise_cyc), 32'd1);
    chk("t5_new_data", 32'(tx_data), 32'h61);
    drain("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
